// File: rtl/fir_3path_serializer.sv
// rtl/fir_3path_serializer.sv - requantizes 3-path FIR frames to Q1.15 and serializes them y0,y1,y2
module fir_3path_serializer #(
    parameter int FRAME_DEPTH = 4,
    parameter bit ROUND_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] y0,
    input  logic [31:0] y1,
    input  logic [31:0] y2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        sat_flag,
    input  logic        sat_clr
);
    localparam int AW = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [15:0]   mem0 [FRAME_DEPTH];
    logic [15:0]   mem1 [FRAME_DEPTH];
    logic [15:0]   mem2 [FRAME_DEPTH];
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    phase;
    logic [15:0]   head;
    logic [16:0]   q0, q1, q2;
    logic          push, pop;

    // Returns {saturated, q1.15 value}; bit 16 marks a clamped result.
    function automatic logic [16:0] requant(input logic [31:0] y);
        logic signed [32:0] r;
        logic signed [17:0] q;
        r = $signed({y[31], y}) + (ROUND_EN ? 33'sd16384 : 33'sd0);
        q = 18'(r >>> 15);
        if (q > 18'sd32767)
            return {1'b1, 16'h7FFF};
        else if (q < -18'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, q[15:0]};
    endfunction

    assign q0 = requant(y0);
    assign q1 = requant(y1);
    assign q2 = requant(y2);

    assign in_ready  = (count < CW'(FRAME_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && (phase == 2'd2);

    always_comb begin
        head = '0;
        case (phase)
            2'd0:    head = mem0[rd_ptr];
            2'd1:    head = mem1[rd_ptr];
            default: head = mem2[rd_ptr];
        endcase
    end

    // Gated so the output reads zero whenever nothing is buffered, including straight after reset.
    assign out_data = out_valid ? head : 16'h0000;

    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr] <= q0[15:0];
            mem1[wr_ptr] <= q1[15:0];
            mem2[wr_ptr] <= q2[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            phase    <= 2'd0;
            sat_flag <= 1'b0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (out_valid && out_ready) begin
                if (phase == 2'd2) begin
                    phase  <= 2'd0;
                    rd_ptr <= rd_ptr + 1'b1;
                end else begin
                    phase <= phase + 2'd1;
                end
            end
            // A new saturation takes priority over a clear in the same cycle.
            if (push && (q0[16] || q1[16] || q2[16]))
                sat_flag <= 1'b1;
            else if (sat_clr)
                sat_flag <= 1'b0;
        end
    end

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(FRAME_DEPTH));
    a_phase_max: assert property (@(posedge clk) disable iff (!rst_n) phase <= 2'd2);
    a_data_known: assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> !$isunknown(out_data));
endmodule

// File: tb/tb_fir_3path_serializer.sv
// tb/tb_fir_3path_serializer.sv - scoreboard bench for fir_3path_serializer
module tb_fir_3path_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready, sat_flag, sat_clr;
    logic [31:0] y0, y1, y2;
    logic [15:0] out_data;
    logic        t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_sat_flag;
    logic [31:0] t_y0, t_y1, t_y2;
    logic [15:0] t_out_data;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          hs_cnt = 0;
    int          cyc = 0;
    bit          stream_mode = 1'b0;
    int          first_stamp = -1;
    int          last_stamp = 0;
    int          stream_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fir_3path_serializer #(.FRAME_DEPTH(4), .ROUND_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    fir_3path_serializer #(.FRAME_DEPTH(4), .ROUND_EN(1'b0)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .y0(t_y0), .y1(t_y1), .y2(t_y2), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .out_data(t_out_data), .sat_flag(t_sat_flag), .sat_clr(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every sample the DUT hands over is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_cnt++;
            if (stream_mode) begin
                if (first_stamp < 0) first_stamp = cyc;
                last_stamp = cyc;
                stream_cnt++;
            end
            if (exp_q.size() == 0)
                chk("unexpected_sample", {16'h0, out_data}, 32'hDEAD_0000);
            else
                chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        y0 = a; y1 = b; y2 = c;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(ea);
                exp_q.push_back(eb);
                exp_q.push_back(ec);
                done = 1'b1;
            end else begin
                @(posedge clk);
                n++;
                if (n > 200) begin
                    chk("push_timeout", 32'd1, 32'd0);
                    done = 1'b1;
                end
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        in_valid = 0; out_ready = 0; sat_clr = 0; y0 = 0; y1 = 0; y2 = 0;
        t_in_valid = 0; t_out_ready = 0; t_y0 = 0; t_y1 = 0; t_y2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Round-half-up boundaries
        out_ready = 1'b1;
        push(32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_BFFF, 16'h0001, 16'h0000, 16'hFFFF);
        push(32'hFFFF_C000, 32'hFFFF_C000, 32'hFFFF_C000, 16'h0000, 16'h0000, 16'h0000);
        drain();
        chk("round_no_sat", sat_flag, 0);

        // Saturation and sticky flag
        push(32'h4000_0000, 32'hBFFF_0000, 32'hC000_0000, 16'h7FFF, 16'h8000, 16'h8000);
        chk("sat_set", sat_flag, 1);
        drain();
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        chk("sat_clear", sat_flag, 0);
        sat_clr = 1'b1;
        push(32'h4000_0000, 32'h0, 32'h0, 16'h7FFF, 16'h0000, 16'h0000);
        sat_clr = 1'b0;
        chk("sat_set_beats_clr", sat_flag, 1);
        drain();
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;

        // Backpressure until full
        out_ready = 1'b0;
        for (int f = 1; f <= 4; f++)
            push(32'((10 * f) << 15), 32'((10 * f + 1) << 15), 32'((10 * f + 2) << 15),
                 16'(10 * f), 16'(10 * f + 1), 16'(10 * f + 2));
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        chk("full_head", out_data, 16'd10);
        repeat (3) @(posedge clk);
        #1 chk("hold_head", out_data, 16'd10);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 chk("ready_before_pop", in_ready, 0);
        @(posedge clk);
        #1 chk("ready_after_pop", in_ready, 1);
        drain();

        // Sustained streaming over pointer wrap
        stream_mode = 1'b1;
        for (int i = 0; i < 20; i++)
            push(32'((3 * i) << 15), 32'((3 * i + 1) << 15), 32'((3 * i + 2) << 15),
                 16'(3 * i), 16'(3 * i + 1), 16'(3 * i + 2));
        drain();
        stream_mode = 1'b0;
        chk("stream_count", stream_cnt, 60);
        chk("stream_span", last_stamp - first_stamp, 59);

        // Truncate mode instance
        t_y0 = 32'h0000_7FFF; t_y1 = 32'hFFFF_FFFF; t_y2 = 32'h0;
        t_in_valid = 1'b1;
        @(posedge clk);
        #1 t_in_valid = 1'b0;
        chk("trunc_valid", t_out_valid, 1);
        chk("trunc_pos", t_out_data, 16'h0000);
        t_out_ready = 1'b1;
        @(posedge clk);
        #1 chk("trunc_neg", t_out_data, 16'hFFFF);
        @(posedge clk);
        #1 chk("trunc_zero", t_out_data, 16'h0000);
        @(posedge clk);
        #1 chk("trunc_empty", t_out_valid, 0);

        // Reset in the middle of frame 2
        out_ready = 1'b1;
        base = hs_cnt;
        push(32'(100 << 15), 32'(101 << 15), 32'(102 << 15), 16'd100, 16'd101, 16'd102);
        push(32'(110 << 15), 32'(111 << 15), 32'(112 << 15), 16'd110, 16'd111, 16'd112);
        n = 0;
        while (hs_cnt < base + 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("reset_reach_y1", hs_cnt, base + 5);
        #2;
        rst_n = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        out_ready = 1'b1;
        push(32'(120 << 15), 32'(121 << 15), 32'(122 << 15), 16'd120, 16'd121, 16'd122);
        drain();
        chk("post_rst_idle", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
